// File: rtl/axis_video_patgen.sv
// AXI4-Stream RGB565 test-pattern source: solid, colour bars, checkerboard, ramp.
// Define AXIS_VIDEO_PATGEN_CROSSHAIR_EN to overlay a white crosshair at the screen centre.
module axis_video_patgen #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int DATA_WIDTH = 16   // project AXI data width; only RGB565 (16) is supported
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  enable_i,
    input  logic [1:0]            mode_i,
    input  logic [15:0]           color_i,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tlast,
    output logic                  busy_o,
    output logic [15:0]           frame_cnt_o
);

    localparam int XW    = $clog2(H_ACTIVE);
    localparam int YW    = (V_ACTIVE > 2) ? $clog2(V_ACTIVE) : 1;
    localparam int BAR_W = H_ACTIVE / 8;
    localparam int BW    = $clog2(BAR_W);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t        state;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [BW-1:0] bar_pos;
    logic [2:0]    bar_idx;
    logic [1:0]    mode_q;
    logic [15:0]   color_q;

    logic [XW-1:0] nx;
    logic [YW-1:0] ny;
    logic [BW-1:0] nbar_pos;
    logic [2:0]    nbar_idx;
    logic          last_x;
    logic          last_y;
    logic          xfer;
    logic          frame_done;
    logic          start_frame;

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = 16'hFFFF;
            3'd1:    c = 16'hFFE0;
            3'd2:    c = 16'h07FF;
            3'd3:    c = 16'h07E0;
            3'd4:    c = 16'hF81F;
            3'd5:    c = 16'hF800;
            3'd6:    c = 16'h001F;
            default: c = 16'h0000;
        endcase
        return c;
    endfunction

    function automatic logic [15:0] pixel(input logic [1:0]    mode,
                                          input logic [15:0]   color,
                                          input logic [XW-1:0] px,
                                          input logic [YW-1:0] py,
                                          input logic [2:0]    bar);
        logic [15:0] x16;
        logic [15:0] y16;
        logic [15:0] d;
        x16 = 16'(px);
        y16 = 16'(py);
        case (mode)
            2'd0:    d = color;
            2'd1:    d = bar_color(bar);
            2'd2:    d = (x16[3] ^ y16[3]) ? 16'hFFFF : 16'h0000;
            default: d = x16 + y16;
        endcase
`ifdef AXIS_VIDEO_PATGEN_CROSSHAIR_EN
        if (x16 == 16'(H_ACTIVE / 2) || y16 == 16'(V_ACTIVE / 2)) begin
            d = 16'hFFFF;
        end
`endif
        return d;
    endfunction

    assign last_x      = (x == XW'(H_ACTIVE - 1));
    assign last_y      = (y == YW'(V_ACTIVE - 1));
    assign xfer        = m_axis_tvalid && m_axis_tready;
    assign frame_done  = (state == ACTIVE) && xfer && last_x && last_y;
    assign start_frame = enable_i && ((state == IDLE) || frame_done);

    // Raster advance; the bar counter replaces an x / BAR_W divide.
    always_comb begin
        // NOTE: every output gets a default first so no latch can be inferred.
        nx       = x + XW'(1);
        ny       = y;
        nbar_pos = bar_pos + BW'(1);
        nbar_idx = bar_idx;
        if (last_x) begin
            nx       = '0;
            ny       = last_y ? '0 : y + YW'(1);
            nbar_pos = '0;
            nbar_idx = '0;
        end else if (bar_pos == BW'(BAR_W - 1)) begin
            nbar_pos = '0;
            nbar_idx = bar_idx + 3'd1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state         <= IDLE;
            x             <= '0;
            y             <= '0;
            bar_pos       <= '0;
            bar_idx       <= '0;
            mode_q        <= '0;
            color_q       <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
            busy_o        <= 1'b0;
            frame_cnt_o   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            if (frame_done) begin
                frame_cnt_o <= frame_cnt_o + 16'd1;
            end

            if (start_frame) begin
                state         <= ACTIVE;
                mode_q        <= mode_i;
                color_q       <= color_i;
                x             <= '0;
                y             <= '0;
                bar_pos       <= '0;
                bar_idx       <= '0;
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= pixel(mode_i, color_i, '0, '0, 3'd0);
                m_axis_tuser  <= 1'b1;
                m_axis_tlast  <= 1'b0;
                busy_o        <= 1'b1;
            end else if (frame_done) begin
                state         <= IDLE;
                x             <= '0;
                y             <= '0;
                bar_pos       <= '0;
                bar_idx       <= '0;
                m_axis_tvalid <= 1'b0;
                m_axis_tdata  <= '0;
                m_axis_tuser  <= 1'b0;
                m_axis_tlast  <= 1'b0;
                busy_o        <= 1'b0;
            end else if ((state == ACTIVE) && xfer) begin
                x            <= nx;
                y            <= ny;
                bar_pos      <= nbar_pos;
                bar_idx      <= nbar_idx;
                m_axis_tdata <= pixel(mode_q, color_q, nx, ny, nbar_idx);
                m_axis_tuser <= 1'b0;
                m_axis_tlast <= (nx == XW'(H_ACTIVE - 1));
            end
        end
    end

endmodule

// File: tb/tb_axis_video_patgen.sv
// Scoreboard bench for axis_video_patgen at 16x4: expected beats are queued per frame
// and compared as the stream transfers; stalled payloads must hold.
module tb_axis_video_patgen;

    localparam int H = 16;
    localparam int V = 4;

    logic        ACLK    = 1'b0;
    logic        ARESETn = 1'b0;
    logic        enable_i = 1'b0;
    logic [1:0]  mode_i   = 2'd0;
    logic [15:0] color_i  = 16'h0000;
    logic        m_axis_tready = 1'b0;
    logic        m_axis_tvalid;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tuser;
    logic        m_axis_tlast;
    logic        busy_o;
    logic [15:0] frame_cnt_o;

    typedef struct packed {
        logic [15:0] data;
        logic        user;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          beats    = 0;
    bit          rand_ready  = 1'b0;
    bit          ready_fixed = 1'b1;
    bit          stalled     = 1'b0;
    logic [17:0] held;

    axis_video_patgen #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .ACLK          (ACLK),
        .ARESETn       (ARESETn),
        .enable_i      (enable_i),
        .mode_i        (mode_i),
        .color_i       (color_i),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .busy_o        (busy_o),
        .frame_cnt_o   (frame_cnt_o)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [15:0] model_pixel(input int mode, input logic [15:0] color,
                                                input int px, input int py);
        logic [15:0] d;
        case (mode)
            0: d = color;
            1: begin
                case (px / (H / 8))
                    0: d = 16'hFFFF;
                    1: d = 16'hFFE0;
                    2: d = 16'h07FF;
                    3: d = 16'h07E0;
                    4: d = 16'hF81F;
                    5: d = 16'hF800;
                    6: d = 16'h001F;
                    default: d = 16'h0000;
                endcase
            end
            2: d = (((px / 8) % 2) != ((py / 8) % 2)) ? 16'hFFFF : 16'h0000;
            default: d = 16'((px + py) % 65536);
        endcase
`ifdef AXIS_VIDEO_PATGEN_CROSSHAIR_EN
        if (px == H / 2 || py == V / 2) d = 16'hFFFF;
`endif
        return d;
    endfunction

    task automatic push_frame(input int mode, input logic [15:0] color);
        for (int yy = 0; yy < V; yy++) begin
            for (int xx = 0; xx < H; xx++) begin
                exp_q.push_back('{data: model_pixel(mode, color, xx, yy),
                                  user: (xx == 0 && yy == 0),
                                  last: (xx == H - 1)});
            end
        end
    endtask

    // Returns just after the clock edge on which beat number target-1 transferred.
    task automatic wait_beats(input int target);
        int n = 0;
        while (beats < target && n < 5000) begin
            @(posedge ACLK);
            n++;
        end
        if (beats < target) check("timeout_beats", beats, target);
    endtask

    initial begin
        forever begin
            @(posedge ACLK);
            #1;
            m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
        end
    end

    // Monitor: a beat seen valid&&ready here transfers on the following rising edge.
    always @(negedge ACLK) begin
        if (!ARESETn) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid", 32'(m_axis_tvalid), 32'd1);
                check("stall_payload", 32'({m_axis_tdata, m_axis_tuser, m_axis_tlast}), 32'(held));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'(exp_q.size()), 32'd1);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check($sformatf("beat%0d_data", beats), 32'(m_axis_tdata), 32'(e.data));
                    check($sformatf("beat%0d_user", beats), 32'(m_axis_tuser), 32'(e.user));
                    check($sformatf("beat%0d_last", beats), 32'(m_axis_tlast), 32'(e.last));
                end
                beats++;
            end
            stalled = m_axis_tvalid && !m_axis_tready;
            held    = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
        end
    end

    initial begin
        int base;
        int n;

        repeat (3) @(negedge ACLK);
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_tdata", 32'(m_axis_tdata), 32'd0);
        check("rst_tuser", 32'(m_axis_tuser), 32'd0);
        check("rst_tlast", 32'(m_axis_tlast), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt_o), 32'd0);
        ARESETn = 1'b1;
        repeat (2) @(negedge ACLK);
        check("idle_tvalid", 32'(m_axis_tvalid), 32'd0);

        // Frame 1: ramp, full throughput; mode changed mid-frame applies to frame 2.
        mode_i   = 2'd3;
        enable_i = 1'b1;
        push_frame(3, 16'h0000);
        @(negedge ACLK);
        check("valid_rise", 32'(m_axis_tvalid), 32'd1);
        check("first_tuser", 32'(m_axis_tuser), 32'd1);
        check("busy_active", 32'(busy_o), 32'd1);
        wait_beats(1);
        mode_i  = 2'd1;
        color_i = 16'h1234;
        push_frame(1, 16'h1234);
        wait_beats(64);
        rand_ready = 1'b1;
        @(negedge ACLK);
        check("f1_frame_cnt", 32'(frame_cnt_o), 32'd1);
        check("b2b_tvalid", 32'(m_axis_tvalid), 32'd1);
        check("b2b_tuser", 32'(m_axis_tuser), 32'd1);

        // Frame 2: colour bars under random backpressure; enable dropped at beat 10.
        wait_beats(64 + 10);
        enable_i = 1'b0;
        wait_beats(128);
        rand_ready = 1'b0;
        repeat (3) @(negedge ACLK);
        check("f2_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("f2_busy", 32'(busy_o), 32'd0);
        check("f2_frame_cnt", 32'(frame_cnt_o), 32'd2);
        check("f2_queue_empty", 32'(exp_q.size()), 32'd0);

        // Frames 3-4: solid colour, colour switched mid-frame 3.
        mode_i     = 2'd0;
        color_i    = 16'hF800;
        enable_i   = 1'b1;
        rand_ready = 1'b1;
        push_frame(0, 16'hF800);
        push_frame(0, 16'h001F);
        wait_beats(128 + 5);
        color_i = 16'h001F;
        wait_beats(128 + 64 + 3);
        enable_i = 1'b0;
        wait_beats(256);
        rand_ready = 1'b0;
        repeat (3) @(negedge ACLK);
        check("f4_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("f4_frame_cnt", 32'(frame_cnt_o), 32'd4);
        check("f4_queue_empty", 32'(exp_q.size()), 32'd0);

        // Frame 5: reset mid-frame, then restart with the checkerboard.
        mode_i   = 2'd3;
        enable_i = 1'b1;
        push_frame(3, 16'h0000);
        wait_beats(256 + 20);
        #2;
        ARESETn = 1'b0;
        #1;
        check("arst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("arst_tdata", 32'(m_axis_tdata), 32'd0);
        check("arst_tuser", 32'(m_axis_tuser), 32'd0);
        check("arst_busy", 32'(busy_o), 32'd0);
        check("arst_frame_cnt", 32'(frame_cnt_o), 32'd0);
        exp_q.delete();
        mode_i = 2'd2;
        push_frame(2, 16'h0000);
        repeat (2) @(negedge ACLK);
        base    = beats;
        ARESETn = 1'b1;
        n = 0;
        do begin
            @(negedge ACLK);
            n++;
        end while (!m_axis_tvalid && n < 20);
        check("restart_tvalid", 32'(m_axis_tvalid), 32'd1);
        check("restart_tuser", 32'(m_axis_tuser), 32'd1);
        check("restart_frame_cnt", 32'(frame_cnt_o), 32'd0);
        wait_beats(base + 5);
        enable_i = 1'b0;
        wait_beats(base + 64);
        repeat (3) @(negedge ACLK);
        check("f6_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("f6_frame_cnt", 32'(frame_cnt_o), 32'd1);
        check("f6_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axis_video_patgen.md
Name: axis_video_patgen

Overview:
- AXI4-Stream video test-pattern source. Emits one RGB565 pixel per beat, in raster order, as the standard project payload: TDATA, TUSER = start-of-frame, TLAST = end-of-line.
- Sits directly upstream of the stream consumers (FIFO / VGA output path).
- Used for bring-up and display verification without a camera or framebuffer.

Parameters:
- H_ACTIVE, 640, active pixels per line; must be a multiple of 8 and at least 16.
- V_ACTIVE, 480, active lines per frame; at least 2.
- DATA_WIDTH, axi_pkg::AXI_DATA_WIDTH (16), TDATA width; only 16 is supported (RGB565).

Ports:
- ACLK  in  1  system clock; all logic is rising-edge.
- ARESETn  in  1  asynchronous active-low reset; one clock domain.
- enable_i  in  1  request streaming; sampled only at frame boundaries.
- mode_i  in  2  pattern select; latched at frame start.
- color_i  in  16  solid colour for mode 0; latched at frame start.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  16  pixel, RGB565.
- m_axis_tuser  out  1  1 on pixel (0,0) only.
- m_axis_tlast  out  1  1 on the last pixel of each line.
- busy_o  out  1  high while a frame is in progress.
- frame_cnt_o  out  16  completed-frame count, wraps at 65535 -> 0.

Behaviour:
- Reset values: all outputs 0; state IDLE; x = y = 0; latched mode and colour = 0.
- All outputs are driven from registers; no combinational path from tready to any output.
- Handshake:
  - A beat transfers when tvalid && tready.
  - While tvalid && !tready, tdata/tuser/tlast are held stable.
  - tvalid never drops without a transfer, except on reset.
- FSM states:
  - IDLE: tvalid = 0. If enable_i = 1, latch mode_i and color_i, load pixel (0,0), go to ACTIVE. tvalid rises in the cycle after enable_i is sampled high.
  - ACTIVE: on each transfer, x++.
    - At x = H_ACTIVE-1: x = 0, y++.
    - At the last pixel (H_ACTIVE-1, V_ACTIVE-1): frame_cnt_o++, then:
      - if enable_i = 1, latch a new mode/colour and present (0,0) in the next cycle (back-to-back frames, no bubble);
      - otherwise go to IDLE.
- enable_i deasserted mid-frame: the frame is always completed. No truncated frames.
- tuser = (x == 0 && y == 0); tlast = (x == H_ACTIVE-1).
- busy_o = 1 in ACTIVE.
- Patterns (x, y = current pixel):
  - mode 0: latched colour.
  - mode 1: 8 vertical bars, each H_ACTIVE/8 wide, in the order FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000. The bar index comes from a bar counter (no divider) that resets at x = 0.
  - mode 2: 8x8 checkerboard. x[3] ^ y[3] = 1 gives FFFF, else 0000.
  - mode 3: ramp, tdata = (x + y) mod 2^16.
- Mode or colour changes mid-frame are ignored until the next frame start.
- ARESETn asserted mid-frame: tvalid drops immediately; after release the block restarts from IDLE with frame_cnt_o = 0.

Optional Feature:
- Macro: AXIS_VIDEO_PATGEN_CROSSHAIR_EN.
- Defined: tdata is forced to FFFF where x == H_ACTIVE/2 or y == V_ACTIVE/2, overriding every mode. tuser/tlast timing is unchanged.
- Undefined: no overlay logic; the pattern is output unmodified.

Test Plan:
- H_ACTIVE=16, V_ACTIVE=4, mode 3, enable held, tready = 1 -> 64 beats with tdata = x + y; tuser only on beat 0; tlast on beats 15/31/47/63; frame_cnt_o = 1 after beat 63; next tuser in the following cycle.
- Mode 1, tready toggled pseudo-randomly -> beats 0-1 = FFFF, 2-3 = FFE0, ..., 14-15 = 0000 on every line; payload held stable on every stalled cycle; no lost or duplicated beats.
- Mode 0, color_i = F800, color_i switched to 001F mid-frame -> whole frame F800; next frame 001F.
- enable_i dropped at beat 10 -> all 64 beats still delivered; then tvalid = 0, busy_o = 0, frame_cnt_o = 1.
- ARESETn pulsed low at beat 20 -> outputs 0 asynchronously; on restart the first beat is (0,0) with tuser = 1 and frame_cnt_o = 0.
- With AXIS_VIDEO_PATGEN_CROSSHAIR_EN defined, mode 2 -> column x = 8 and row y = 2 read FFFF; all other pixels follow the checkerboard.
